// File: rtl/ising_pkg.sv
// ising_pkg: shared encodings for the Ising readout path.
//   - state_t: measurement FSM encoding (IDLE, SETTLE, SAMPLE, DONE).
//   - ADDR_*:  register map offsets of the readout read port.
//   - max_int: elaboration-time helper used to size counters.
package ising_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int ADDR_STATUS     = 0;
    localparam int ADDR_SPINS      = 1;
    localparam int ADDR_COUNT_BASE = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_sync.sv
// phase_sync: WIDTH-bit two-flop synchronizer for asynchronous oscillator
// outputs.
//   clk, ising_rstn : clock, asynchronous active-low clear of both stages
//   d               : raw asynchronous inputs
//   q               : synchronized outputs, two clk cycles behind d
module phase_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             ising_rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spin_readout.sv
// spin_readout: measures NUM_SPINS oscillator phases against a reference
// oscillator over WINDOW_CYCLES samples and resolves each to a spin bit by
// majority vote; results are exposed through a 1-cycle-latency read port.
//   clk, ising_rstn : clock, asynchronous active-low reset
//   start           : single-cycle measurement request (honoured in IDLE only)
//   osc_in, osc_ref : raw oscillator / reference phase outputs (asynchronous)
//   rd_en, rd_addr  : read strobe and register address
//   rdata, rvalid   : read data, valid the cycle after rd_en
//   busy            : measurement in progress (SETTLE or SAMPLE)
//   done            : one-cycle pulse in the cycle results are committed
// Register map: 0 status {done_sticky, busy}, 1 spin bits, 2+i agree[i].
module spin_readout
    import ising_pkg::*;
#(
    parameter int NUM_SPINS     = 8,
    parameter int WINDOW_CYCLES = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int ADDR_W        = 8
) (
    input  logic                 clk,
    input  logic                 ising_rstn,
    input  logic                 start,
    input  logic [NUM_SPINS-1:0] osc_in,
    input  logic                 osc_ref,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W  = $clog2(WINDOW_CYCLES + 1);
    localparam int PH_MAX = max_int(SETTLE_CYCLES, WINDOW_CYCLES);
    localparam int PH_W   = $clog2(PH_MAX);

    // Synchronize spins and reference together so they share one delay.
    logic [NUM_SPINS:0]   sync_q;
    logic [NUM_SPINS-1:0] osc_s;
    logic                 ref_s;

    phase_sync #(.WIDTH(NUM_SPINS + 1)) u_sync (
        .clk        (clk),
        .ising_rstn (ising_rstn),
        .d          ({osc_ref, osc_in}),
        .q          (sync_q)
    );

    assign ref_s = sync_q[NUM_SPINS];
    assign osc_s = sync_q[NUM_SPINS-1:0];

    state_t                           state, state_nxt;
    logic [PH_W-1:0]                  phase;
    logic                             clr_work, sample_en, commit;
    logic [NUM_SPINS-1:0][CNT_W-1:0]  agree;
    logic [NUM_SPINS-1:0][CNT_W-1:0]  res_agree;
    logic [NUM_SPINS-1:0]             spin_q;
    logic                             done_sticky;
    logic [31:0]                      rd_mux;

    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_work  = 1'b0;
        sample_en = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                    clr_work  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (phase == PH_W'(SETTLE_CYCLES - 1)) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                sample_en = 1'b1;
                if (phase == PH_W'(WINDOW_CYCLES - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);

    // Phase restarts on every state change so SETTLE and SAMPLE each count
    // from zero.
    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn)             phase <= '0;
        else if (state_nxt != state) phase <= '0;
        else if (busy)               phase <= phase + PH_W'(1);
    end

    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            agree <= '0;
        end else if (clr_work) begin
            agree <= '0;
        end else if (sample_en) begin
            for (int i = 0; i < NUM_SPINS; i++)
                if (osc_s[i] == ref_s) agree[i] <= agree[i] + CNT_W'(1);
        end
    end

    // Strict majority: a tie at exactly half the window resolves to 0.
    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            spin_q    <= '0;
            res_agree <= '0;
        end else if (commit) begin
            res_agree <= agree;
            for (int i = 0; i < NUM_SPINS; i++)
                spin_q[i] <= (agree[i] > CNT_W'(WINDOW_CYCLES / 2));
        end
    end

    // A commit in the same cycle as a status read keeps the flag set.
    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn)
            done_sticky <= 1'b0;
        else if (commit)
            done_sticky <= 1'b1;
        else if (rd_en && (rd_addr == ADDR_W'(ADDR_STATUS)))
            done_sticky <= 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        if (rd_addr == ADDR_W'(ADDR_STATUS)) begin
            rd_mux = {30'b0, done_sticky, busy};
        end else if (rd_addr == ADDR_W'(ADDR_SPINS)) begin
            rd_mux = 32'(spin_q);
        end else begin
            for (int i = 0; i < NUM_SPINS; i++)
                if (rd_addr == ADDR_W'(ADDR_COUNT_BASE + i))
                    rd_mux = 32'(res_agree[i]);
        end
    end

    // rdata holds its last value between reads.
    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) rdata <= rd_mux;
        end
    end

endmodule

// File: doc/spin_readout.md
Name: spin_readout

Overview:
- Read-side counterpart to the coupled-counter array: samples the NUM_SPINS oscillator phase outputs against a reference oscillator over a fixed window.
- Resolves each oscillator to a binary spin by majority vote.
- Exposes spin bits, per-spin agreement counts and status through a synchronous register read port to the host/AXI bridge.

Parameters:
- NUM_SPINS, 8, number of oscillator outputs sampled (1..32).
- WINDOW_CYCLES, 64, sample cycles per measurement; must be even, at least 2.
- SETTLE_CYCLES, 4, cycles discarded after start to flush synchronizers (at least 2).
- ADDR_W, 8, read address width.

Ports:
- clk, input, 1, system clock.
- ising_rstn, input, 1, reset, asynchronous, active-low.
- start, input, 1, single-cycle request to begin a measurement.
- osc_in, input, NUM_SPINS, raw oscillator phase outputs (asynchronous to clk).
- osc_ref, input, 1, raw reference oscillator output (asynchronous).
- rd_en, input, 1, read strobe.
- rd_addr, input, ADDR_W, register address.
- rdata, output, 32, read data, valid when rvalid=1.
- rvalid, output, 1, read data valid.
- busy, output, 1, high in SETTLE or SAMPLE.
- done, output, 1, one-cycle pulse when results update.

Behaviour:
- Reset (ising_rstn low, async): state IDLE; all counters, spin register and agreement counts cleared; rdata=0, rvalid=0, busy=0, done=0; synchronizer flops cleared.
- Synchronization:
  - osc_in and osc_ref each pass a 2-flop synchronizer.
  - All comparisons use the synchronized values osc_s and ref_s.
- Counter widths: CNT_W = clog2(WINDOW_CYCLES+1) for agreement counts; a separate phase counter is sized for max(SETTLE_CYCLES, WINDOW_CYCLES).
- FSM, IDLE:
  - start=1 -> SETTLE; phase counter=0; working agreement counters cleared.
  - start=0 -> remain in IDLE.
- FSM, SETTLE:
  - Phase counter increments each cycle.
  - When it reaches SETTLE_CYCLES-1 -> SAMPLE, phase counter=0.
- FSM, SAMPLE:
  - Each cycle, for every i: if osc_s[i]==ref_s, working agree[i]+=1.
  - After WINDOW_CYCLES sample cycles (phase counter = WINDOW_CYCLES-1, that cycle's sample included) -> DONE.
- FSM, DONE (1 cycle):
  - Commit spin[i] = (agree[i] > WINDOW_CYCLES/2); a tie gives 0.
  - Copy working counts to result counts.
  - done=1 this cycle; -> IDLE.
- Latency: done asserts SETTLE_CYCLES + WINDOW_CYCLES + 1 cycles after the start cycle.
- Result registers hold the previous measurement until the next DONE commit; reads during busy return old results.
- start while not in IDLE (including the DONE cycle) is ignored; no queuing.
- Agreement counters cannot overflow: CNT_W covers WINDOW_CYCLES exactly.
- Reset mid-measurement aborts to IDLE and clears results; no done pulse is generated.
- Read port:
  - rd_en sampled at clk; rvalid=1 and rdata valid on the following cycle (1-cycle latency).
  - Back-to-back reads are allowed every cycle.
  - rdata holds its last value when rvalid=0.
- Address map:
  - addr 0: status {30'b0, done_sticky, busy}. done_sticky sets on DONE and clears on a read of addr 0 (the read returns 1 first). Simultaneous set and read-clear: set wins.
  - addr 1: spin bits, zero-extended to 32.
  - addr 2+i (i<NUM_SPINS): result agree[i], zero-extended.
  - Any other addr returns 0.

Decomposition:
- Shared package (ising_pkg): FSM state encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3) and the address constants ADDR_STATUS=0, ADDR_SPINS=1, ADDR_COUNT_BASE=2.
- Sub-module phase_sync: parameterized-width 2-flop synchronizer with async active-low clear, instantiated for osc_in and osc_ref together (width NUM_SPINS+1).

Test Plan:
- All in phase: osc_in all = osc_ref toggling every 3 clk; start -> done after 69 cycles; addr1=0xFF; addr2..9=64 each.
- Anti-phase spin 3: osc_in[3] = ~osc_ref, others in phase -> addr1=0xF7; addr5=0; others 64.
- Tie: osc_in[0] agrees on exactly 32 of 64 sample cycles (driven synchronously, pre-aligned for the 2-cycle synchronizer delay) -> addr2=32; spin bit0=0.
- start re-asserted at cycle 10 of SAMPLE -> ignored; exactly one done pulse; busy continuous for 68 cycles.
- Reset mid-SAMPLE (ising_rstn low 2 cycles at sample 20), after a prior completed run -> busy=0, addr1=0, addr2..9=0, no done; a new start completes normally.
- Reads: addr 0 after done returns 0x2, a second read returns 0x0; addr 0x7F returns 0; back-to-back reads of addr 1,2,3 return data on consecutive cycles with 1-cycle latency.
